// File: rtl/gardner_loop_ctrl.sv
// Symbol-timing loop controller: PI loop filter on the sampled Gardner error
// drives skip/stall adjustments of a modulo-SPS sample-phase counter.
module gardner_loop_ctrl #(
    parameter int WIDTH       = 16,
    parameter int SPS         = 32,
    parameter int KP_SHIFT    = 4,
    parameter int KI_SHIFT    = 10,
    parameter int ACC_WIDTH   = 24,
    parameter int STEP_THRESH = 4096,
    parameter int LOCK_THRESH = 512,
    parameter int LOCK_COUNT  = 16
) (
    input  logic                        clk_32M768,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [WIDTH-1:0]     error_n,
    output logic [$clog2(SPS)-1:0]      phase,
    output logic                        strobe_sym,
    output logic                        strobe_mid,
    output logic                        adj_adv,
    output logic                        adj_ret,
    output logic                        locked,
    output logic signed [ACC_WIDTH-1:0] integ
);
    localparam int PW = $clog2(SPS);
    localparam int SW = ACC_WIDTH + 2;
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int LW = WIDTH + 1;

    localparam logic [PW-1:0] PH_LAST = PW'(SPS - 1);
    localparam logic [PW-1:0] PH_STEP = PW'(SPS / 4);
    localparam logic [PW-1:0] PH_SKIP = PW'(SPS / 4 + 2);
    localparam logic [PW-1:0] PH_MID  = PW'(SPS / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_COUNT - 1);

    localparam logic signed [SW-1:0] ONE     = SW'(1);
    localparam logic signed [SW-1:0] ACC_MAX = (ONE <<< (ACC_WIDTH - 1)) - ONE;
    localparam logic signed [SW-1:0] ACC_MIN = -(ONE <<< (ACC_WIDTH - 1));
    localparam logic signed [SW-1:0] THRESH  = SW'(STEP_THRESH);

    localparam logic signed [WIDTH-1:0] E_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]        E_MAG_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [LW-1:0]           LOCK_T    = LW'(LOCK_THRESH);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
    typedef enum logic [1:0] {STEP_NONE, STEP_ADV, STEP_RET} step_t;

    state_t state, state_nx;
    step_t  pend, pend_nx;

    logic [CW-1:0]               lock_cnt, cnt_nx;
    logic signed [ACC_WIDTH-1:0] ctrl, acc, integ_nx, ctrl_nx, acc_nx;
    logic [PW-1:0]               ph_nx;
    logic                        adv_nx, ret_nx;
    logic                        upd, dec, in_win;
    logic [WIDTH-1:0]            e_mag;
    logic [7:0]                  kp, ki;
    logic signed [SW-1:0]        e_ext, sum;

    function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if (v > ACC_MAX) return ACC_MAX[ACC_WIDTH-1:0];
        if (v < ACC_MIN) return ACC_MIN[ACC_WIDTH-1:0];
        return v[ACC_WIDTH-1:0];
    endfunction

    // Loop update at the last phase of a symbol; step decision one cycle later.
    assign upd = (state != IDLE) && (phase == PH_LAST);
    assign dec = (state != IDLE) && (phase == '0);

    assign e_mag  = (error_n == E_MIN) ? E_MAG_MAX
                  : (error_n[WIDTH-1] ? $unsigned(-error_n) : $unsigned(error_n));
    assign in_win = {1'b0, e_mag} < LOCK_T;

    always_comb begin
        state_nx = state;
        cnt_nx   = lock_cnt;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                IDLE: state_nx = ACQUIRE;
                ACQUIRE, LOCKED: begin
                    if (upd) begin
                        if ((state == ACQUIRE) ? in_win : !in_win) begin
                            if (lock_cnt == CNT_LAST) begin
                                state_nx = (state == ACQUIRE) ? LOCKED : ACQUIRE;
                                cnt_nx   = '0;
                            end else begin
                                cnt_nx = lock_cnt + CW'(1);
                            end
                        end else begin
                            cnt_nx = '0;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        kp       = (state == LOCKED) ? 8'(KP_SHIFT + 2) : 8'(KP_SHIFT);
        ki       = (state == LOCKED) ? 8'(KI_SHIFT + 2) : 8'(KI_SHIFT);
        e_ext    = SW'(error_n);
        sum      = '0;
        integ_nx = integ;
        ctrl_nx  = ctrl;
        acc_nx   = acc;
        pend_nx  = pend;
        ph_nx    = '0;
        adv_nx   = 1'b0;
        ret_nx   = 1'b0;

        if (upd) begin
            integ_nx = sat(SW'(integ) + (e_ext >>> ki));
            ctrl_nx  = sat((e_ext >>> kp) + SW'(integ_nx));
        end

        if (dec) begin
            sum = SW'(acc) + SW'(ctrl);
            if (sum >= THRESH) begin
                acc_nx  = sat(sum - THRESH);
                pend_nx = STEP_ADV;
            end else if (sum <= -THRESH) begin
                acc_nx  = sat(sum + THRESH);
                pend_nx = STEP_RET;
            end else begin
                acc_nx  = sat(sum);
                pend_nx = STEP_NONE;
            end
        end

        // Leaving IDLE keeps phase at 0 for the first active cycle.
        if (state != IDLE) begin
            if (phase == PH_STEP && pend == STEP_ADV) begin
                ph_nx   = PH_SKIP;
                adv_nx  = 1'b1;
                pend_nx = STEP_NONE;
            end else if (phase == PH_STEP && pend == STEP_RET) begin
                ph_nx   = PH_STEP;
                ret_nx  = 1'b1;
                pend_nx = STEP_NONE;
            end else if (phase == PH_LAST) begin
                ph_nx = '0;
            end else begin
                ph_nx = phase + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_32M768) begin
        if (rst) begin
            state    <= IDLE;
            lock_cnt <= '0;
        end else begin
            state    <= state_nx;
            lock_cnt <= cnt_nx;
        end
    end

    always_ff @(posedge clk_32M768) begin
        if (rst || state_nx == IDLE) begin
            phase      <= '0;
            strobe_sym <= 1'b0;
            strobe_mid <= 1'b0;
            adj_adv    <= 1'b0;
            adj_ret    <= 1'b0;
            locked     <= 1'b0;
            integ      <= '0;
            ctrl       <= '0;
            acc        <= '0;
            pend       <= STEP_NONE;
        end else begin
            phase      <= ph_nx;
            strobe_sym <= (ph_nx == '0);
            strobe_mid <= (ph_nx == PH_MID);
            adj_adv    <= adv_nx;
            adj_ret    <= ret_nx;
            locked     <= (state_nx == LOCKED);
            integ      <= integ_nx;
            ctrl       <= ctrl_nx;
            acc        <= acc_nx;
            pend       <= pend_nx;
        end
    end
endmodule

// File: tb/tb_gardner_loop_ctrl.sv
// Bench for gardner_loop_ctrl: directed vector table, hand sequences and a
// randomized run against a behavioural model of the loop.
module tb_gardner_loop_ctrl;
    localparam int     SPS = 32;
    localparam int     Q   = SPS / 4;
    localparam int     KP  = 4;
    localparam int     KI  = 10;
    localparam longint TH  = 4096;
    localparam int     LT  = 512;
    localparam int     LC  = 16;
    localparam longint AMAX = 64'sd8388607;
    localparam longint AMIN = -64'sd8388608;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic en_i = 1'b0;
    logic signed [15:0] error_i = '0;

    logic [4:0]         phase;
    logic               strobe_sym, strobe_mid, adj_adv, adj_ret, locked;
    logic signed [23:0] integ;
    logic [4:0]         phase_s;
    logic               strobe_sym_s, strobe_mid_s, adj_adv_s, adj_ret_s, locked_s;
    logic signed [23:0] integ_s;

    int vectors = 0;
    int miscompares = 0;

    gardner_loop_ctrl dut (
        .clk_32M768(clk), .rst(rst_i), .en(en_i), .error_n(error_i),
        .phase(phase), .strobe_sym(strobe_sym), .strobe_mid(strobe_mid),
        .adj_adv(adj_adv), .adj_ret(adj_ret), .locked(locked), .integ(integ)
    );

    // Unity gains so the integrator can reach saturation within a short run.
    gardner_loop_ctrl #(.KP_SHIFT(0), .KI_SHIFT(0)) dut_sat (
        .clk_32M768(clk), .rst(rst_i), .en(en_i), .error_n(error_i),
        .phase(phase_s), .strobe_sym(strobe_sym_s), .strobe_mid(strobe_mid_s),
        .adj_adv(adj_adv_s), .adj_ret(adj_ret_s), .locked(locked_s), .integ(integ_s)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 acquire, 2 locked; pend +1 adv, -1 ret.
    int     m_mode, m_phase, m_pend, m_cnt;
    longint m_integ, m_ctrl, m_acc;
    bit     m_sym, m_mid, m_adv, m_ret;

    function automatic longint clamp(input longint v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    function automatic longint floordiv(input longint v, input int sh);
        longint d = longint'(1) << sh;
        longint q = v / d;
        if (v < 0 && (v % d) != 0) q = q - 1;
        return q;
    endfunction

    task automatic model_step(input bit r, input bit e, input int err);
        int old_ph, kp, ki, mag;
        bit good;
        longint s;
        if (r || !e) begin
            m_mode = 0; m_phase = 0; m_pend = 0; m_cnt = 0;
            m_integ = 0; m_ctrl = 0; m_acc = 0;
            m_sym = 0; m_mid = 0; m_adv = 0; m_ret = 0;
            return;
        end
        if (m_mode == 0) begin
            m_mode = 1; m_phase = 0; m_sym = 1; m_mid = 0; m_adv = 0; m_ret = 0;
            return;
        end
        old_ph = m_phase;
        m_adv = 0;
        m_ret = 0;
        if (old_ph == SPS - 1) begin
            kp = (m_mode == 2) ? KP + 2 : KP;
            ki = (m_mode == 2) ? KI + 2 : KI;
            m_integ = clamp(m_integ + floordiv(err, ki));
            m_ctrl  = clamp(floordiv(err, kp) + m_integ);
            mag  = (err == -32768) ? 32767 : ((err < 0) ? -err : err);
            good = (m_mode == 1) ? (mag < LT) : (mag >= LT);
            m_cnt = good ? m_cnt + 1 : 0;
            if (m_cnt == LC) begin
                m_mode = 3 - m_mode;
                m_cnt  = 0;
            end
        end
        if (old_ph == 0) begin
            s = m_acc + m_ctrl;
            if (s >= TH) begin m_acc = clamp(s - TH); m_pend = 1; end
            else if (s <= -TH) begin m_acc = clamp(s + TH); m_pend = -1; end
            else begin m_acc = clamp(s); m_pend = 0; end
        end
        if (old_ph == Q && m_pend == 1) begin
            m_phase = Q + 2; m_adv = 1; m_pend = 0;
        end else if (old_ph == Q && m_pend == -1) begin
            m_ret = 1; m_pend = 0;
        end else begin
            m_phase = (old_ph + 1) % SPS;
        end
        m_sym = (m_phase == 0);
        m_mid = (m_phase == SPS / 2);
    endtask

    task automatic check_cycle();
        vectors++;
        if (phase !== 5'(m_phase) || strobe_sym !== m_sym || strobe_mid !== m_mid ||
            adj_adv !== m_adv || adj_ret !== m_ret || locked !== (m_mode == 2) ||
            integ !== 24'(m_integ)) begin
            miscompares++;
            $display("FAIL model t=%0t: got ph=%0d sym=%0b mid=%0b adv=%0b ret=%0b lk=%0b integ=%0d, want ph=%0d sym=%0b mid=%0b adv=%0b ret=%0b lk=%0b integ=%0d",
                     $time, phase, strobe_sym, strobe_mid, adj_adv, adj_ret, locked, integ,
                     m_phase, m_sym, m_mid, m_adv, m_ret, (m_mode == 2), m_integ);
        end
    endtask

    task automatic check_val(input string name, input longint got, input longint want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic tick(input bit r, input bit e, input int err);
        rst_i = r;
        en_i = e;
        error_i = 16'(err);
        @(posedge clk);
        model_step(r, e, err);
        @(negedge clk);
        check_cycle();
    endtask

    typedef struct {
        int err;
        int cycles;
        int n_sym;
        int n_mid;
        int n_adv;
        int n_ret;
        int lock_end;
        int first_adj;
    } row_t;

    row_t rows[8];

    initial begin
        int n_sym, n_mid, n_adv, n_ret, first, adv_in_sym, max_adv, ret_s_cnt;
        bit wrapped, mid_bad;
        longint prev;

        rows[0] = '{0,      520, 17, 16, 0, 0, 1, -1};
        rows[1] = '{8192,   300, 10,  9, 1, 0, 0, 265};
        rows[2] = '{-8192,  300, 10,  9, 0, 1, 0, 265};
        rows[3] = '{511,    520, 17, 16, 0, 0, 1, -1};
        rows[4] = '{512,    520, 17, 16, 0, 0, 0, -1};
        rows[5] = '{-511,   520, 17, 16, 0, 0, 1, -1};
        rows[6] = '{-512,   520, 17, 16, 0, 0, 0, -1};
        rows[7] = '{-32768, 100,  4,  3, 0, 1, 0, 73};

        for (int i = 0; i < 3; i++) tick(1, 0, 0);
        n_sym = 0;
        for (int i = 0; i < 100; i++) begin
            tick(0, 0, 1234);
            if (strobe_sym || strobe_mid) n_sym++;
        end
        check_val("idle_strobes", n_sym, 0);

        foreach (rows[i]) begin
            tick(0, 0, 0);
            tick(0, 0, 0);
            n_sym = 0; n_mid = 0; n_adv = 0; n_ret = 0; first = -1;
            for (int c = 0; c < rows[i].cycles; c++) begin
                tick(0, 1, rows[i].err);
                if (strobe_sym) n_sym++;
                if (strobe_mid) n_mid++;
                if (adj_adv) n_adv++;
                if (adj_ret) n_ret++;
                if ((adj_adv || adj_ret) && first < 0) first = c;
                if (rows[i].first_adj >= 0) begin
                    if (c == rows[i].first_adj - 1) check_val("ph_before_step", phase, Q);
                    if (c == rows[i].first_adj)
                        check_val("ph_at_step", phase, (rows[i].n_ret > 0) ? Q : Q + 2);
                    if (c == rows[i].first_adj + 1)
                        check_val("ph_after_step", phase, (rows[i].n_ret > 0) ? Q + 1 : Q + 3);
                end
            end
            check_val($sformatf("row%0d_sym", i), n_sym, rows[i].n_sym);
            check_val($sformatf("row%0d_mid", i), n_mid, rows[i].n_mid);
            check_val($sformatf("row%0d_adv", i), n_adv, rows[i].n_adv);
            check_val($sformatf("row%0d_ret", i), n_ret, rows[i].n_ret);
            check_val($sformatf("row%0d_locked", i), locked, rows[i].lock_end);
            check_val($sformatf("row%0d_first_adj", i), first, rows[i].first_adj);
        end

        // Lock on zero error, then lose lock on |error|=1000 after 16 updates.
        tick(0, 0, 0);
        for (int c = 0; c < 1030; c++) begin
            tick(0, 1, (c < 520) ? 0 : 1000);
            if (c == 511) check_val("lock_pre", locked, 0);
            if (c == 512) check_val("lock_rise", locked, 1);
            if (c == 1023) check_val("unlock_pre", locked, 1);
            if (c == 1024) check_val("unlock_fall", locked, 0);
        end

        // Drop en mid-symbol with a non-zero integrator.
        tick(0, 0, 0);
        for (int c = 0; c < 100; c++) tick(0, 1, 8192);
        check_val("integ_3upd", integ, 24);
        tick(0, 0, 8192);
        check_val("drop_integ", integ, 0);
        check_val("drop_phase", phase, 0);
        check_val("drop_sym", strobe_sym, 0);

        // Randomized segments, including occasional en drops and resets.
        for (int seg = 0; seg < 25; seg++) begin
            int mode, fixed, err;
            mode  = int'($urandom_range(0, 4));
            fixed = int'($urandom_range(2000, 9000));
            if ($urandom_range(0, 1) == 1) fixed = -fixed;
            for (int c = 0; c < 800; c++) begin
                case (mode)
                    0: err = int'($urandom_range(0, 1022)) - 511;
                    1: begin
                        err = int'($urandom_range(512, 12000));
                        if ($urandom_range(0, 1) == 1) err = -err;
                    end
                    2: err = int'($urandom_range(0, 65535)) - 32768;
                    3: err = 0;
                    default: err = fixed;
                endcase
                tick($urandom_range(0, 4999) == 0, $urandom_range(0, 2999) != 0, err);
            end
        end

        // Saturation run on the unity-gain instance.
        tick(1, 0, 0);
        prev = 0; wrapped = 0; mid_bad = 0;
        adv_in_sym = 0; max_adv = 0; ret_s_cnt = 0;
        for (int c = 0; c < 9000; c++) begin
            tick(0, 1, 32767);
            if (longint'(integ_s) < prev) wrapped = 1;
            prev = longint'(integ_s);
            if (strobe_sym_s) adv_in_sym = 0;
            if (adj_adv_s) adv_in_sym++;
            if (adv_in_sym > max_adv) max_adv = adv_in_sym;
            if (adj_ret_s || locked_s) ret_s_cnt++;
            if (strobe_mid_s != (phase_s == 5'd16)) mid_bad = 1;
        end
        check_val("sat_integ", integ_s, AMAX);
        check_val("sat_nowrap", wrapped, 0);
        check_val("sat_adv_per_sym", max_adv, 1);
        check_val("sat_no_ret_or_lock", ret_s_cnt, 0);
        check_val("sat_mid_strobe", mid_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
